ahb_lite_des_master: RTL
========================

# ahb_lite_des_master

AHB-Lite single-transfer master that drives the Triple-DES slave from the local side of the design. It accepts one job (mode, three keys, one 64-bit block) and writes the slave's five register windows in order. It then polls the result with read transfers and returns the 64-bit result with a done pulse. It sits between the host-side job source and the AHB-Lite interconnect, as the initiator for the DES slave controller.

## Interface
- POLL_MAX, 64: maximum result-read attempts before timeout (≥1).
- BASE_ADDR, 32'h0000_0000: base of the DES slave address map.
- HCLK  in  1  bus clock, all logic on rising edge.
- HRESET  in  1  reset HRESET, asynchronous, active-low; clock HCLK.
- start  in  1  job request; sampled only in IDLE.
- mode  in  1  encryption type written to slave bit 0 (1 = encrypt).
- key1_in, key2_in, key3_in  in  64 each  DES keys.
- data_in  in  64  plaintext/ciphertext block.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job end.
- error  out  1  valid with done: 1 = HRESP error or poll timeout.
- data_out  out  64  result; held until next accepted start.
- HADDR  out  32; HWRITE  out  1; HTRANS  out  2; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HMASTLOCK  out  1; HWDATA  out  64.
- HRDATA  in  64; HREADY  in  1; HRESP  in  1.

## Operation
- Constant drives: HSIZE=3'b011, HBURST=3'b000, HPROT=4'h1, HMASTLOCK=0. Only HTRANS IDLE (2'b00) and NONSEQ (2'b10) used.
- Write order, offsets from BASE_ADDR: mode 0x0000 (HWDATA = {63'b0, mode}), key1 0x0400, key2 0x0800, key3 0x0C00, data 0x1000. The data write triggers the engine.
- Result read address: BASE_ADDR+0x0000. Reads never target 0x1000, which would retrigger the engine.
- Job inputs are captured into internal registers at start acceptance; later input changes are ignored.
- FSM states:
  - IDLE: start=1 captures inputs, sets idx=0, goes to WR_ADDR.
  - WR_ADDR: drive NONSEQ, HWRITE=1, HADDR=map[idx]. If HREADY=1, go to WR_DATA; otherwise hold.
  - WR_DATA: HTRANS=IDLE, HWDATA=item[idx]. Wait for HREADY=1. Then idx==4 goes to RD_ADDR with poll=0; otherwise idx+1 and back to WR_ADDR.
  - RD_ADDR: drive NONSEQ, HWRITE=0. If HREADY=1, go to RD_DATA.
  - RD_DATA: HTRANS=IDLE. On HREADY=1, sample HRDATA:
    - nonzero: data_out=HRDATA, go to FINISH with error=0.
    - zero and poll==POLL_MAX-1: go to FINISH with error=1.
    - otherwise: poll+1, go to RD_ADDR.
  - FINISH: done=1 for one cycle, busy=0 next, return to IDLE.
- Error response: HRESP=1 in any data phase aborts the job.
  - First cycle (HREADY=0): HTRANS forced IDLE.
  - Second cycle (HREADY=1): go to FINISH with error=1. data_out is left unchanged.
- A zero result is indistinguishable from "not ready" and is reported as a timeout. This is a known limitation.
- start while busy is ignored; no queueing.

## Timing
- Reset values: HTRANS=00, HWRITE=0, HADDR=BASE_ADDR, HWDATA=0, busy=0, done=0, error=0, data_out=0; state IDLE, idx=0, poll=0.
- Zero-wait bus: start accepted at edge 0; first NONSEQ visible in the following cycle.
- Each transfer is non-pipelined: 1 address cycle, then 1+ data cycles. Five writes take 10 cycles minimum.
- Each poll takes 2 cycles minimum.
- Best-case job latency (result on first poll): 13 cycles from start acceptance to done.
- Wait states: every HREADY=0 cycle stretches the current phase by one; address, HWRITE and HWDATA stay stable.
- Reset mid-job: the asynchronous return to reset values takes effect immediately; no done pulse is produced.
- Registers: poll counter is $clog2(POLL_MAX)+1 bits; idx is 3 bits.

## Structure
- Shared package des_ahb_pkg:
  - register offsets: TYPE 0x0000, KEY1 0x0400, KEY2 0x0800, KEY3 0x0C00, DATA 0x1000, LIMIT 0x1400;
  - HTRANS_IDLE/NONSEQ constants, HSIZE_64, HPROT_DATA;
  - master state enum.
- Single module; no sub-module needed. The address/data map lookup is a local function indexed by idx.

## Test plan
- Zero-wait slave, result 64'h0123_4567_89AB_CDEF ready on first poll:
  - observe write sequence addresses 0x0,0x400,0x800,0xC00,0x1000 with correct HWDATA;
  - done at cycle 13, error=0, data_out matches.
- Slave inserts 2 wait states on the key2 data phase: HADDR/HWDATA stay stable; done is delayed by exactly 2 cycles.
- Result returns 0 for 3 polls, then 64'hDEAD_BEEF_0000_0001: 4 reads at 0x0; done, error=0.
- POLL_MAX=4, result always 0: exactly 4 reads, then done with error=1; data_out unchanged.
- Two-cycle error response on the key3 write: HTRANS=IDLE in the first error cycle; done+error next; no further transfers.
- Other checks:
  - start pulsed while busy: ignored;
  - HRESET asserted mid-poll: all outputs return to reset values immediately;
  - new start after reset completes normally.

Source files
------------

// File: rtl/des_ahb_pkg.sv
// des_ahb_pkg: shared register map, AHB-Lite encodings and master state type
// for the Triple-DES slave and the master that drives it.
package des_ahb_pkg;
    localparam logic [31:0] OFF_TYPE  = 32'h0000_0000;
    localparam logic [31:0] OFF_KEY1  = 32'h0000_0400;
    localparam logic [31:0] OFF_KEY2  = 32'h0000_0800;
    localparam logic [31:0] OFF_KEY3  = 32'h0000_0C00;
    localparam logic [31:0] OFF_DATA  = 32'h0000_1000;
    localparam logic [31:0] OFF_LIMIT = 32'h0000_1400;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_64      = 3'b011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'h1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_FINISH
    } mst_state_t;
endpackage

// File: rtl/ahb_lite_des_master_if.sv
// ahb_lite_des_master_if: AHB-Lite signal bundle between the DES job master
// and the interconnect / DES slave.
interface ahb_lite_des_master_if;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    modport master (
        output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_des_master.sv
// ahb_lite_des_master: loads one Triple-DES job into the slave with five
// single writes, then polls the result register until nonzero or timeout.
module ahb_lite_des_master
    import des_ahb_pkg::*;
#(
    parameter int          POLL_MAX  = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        mode,
    input  logic [63:0] key1_in,
    input  logic [63:0] key2_in,
    input  logic [63:0] key3_in,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] data_out,
    ahb_lite_des_master_if.master bus
);
    localparam int              PW        = $clog2(POLL_MAX) + 1;
    localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_MAX - 1);

    mst_state_t    r_state, w_next;
    logic [2:0]    r_idx;
    logic [PW-1:0] r_poll;
    logic          r_mode, r_busy, r_done, r_error;
    logic [63:0]   r_key1, r_key2, r_key3, r_blk, r_dout;
    logic [63:0]   w_item;
    logic          w_wr, w_wdone, w_rdone, w_hit, w_last;

    function automatic logic [31:0] map_addr(input logic [2:0] i);
        return BASE_ADDR + (i == 3'd0 ? OFF_TYPE :
                            i == 3'd1 ? OFF_KEY1 :
                            i == 3'd2 ? OFF_KEY2 :
                            i == 3'd3 ? OFF_KEY3 :
                            i == 3'd4 ? OFF_DATA : OFF_LIMIT);
    endfunction

    always_comb begin
        w_item = r_idx == 3'd0 ? {63'd0, r_mode} :
                 r_idx == 3'd1 ? r_key1 :
                 r_idx == 3'd2 ? r_key2 :
                 r_idx == 3'd3 ? r_key3 : r_blk;
    end

    assign w_wr    = (r_state == ST_WR_ADDR) || (r_state == ST_WR_DATA);
    assign w_wdone = (r_state == ST_WR_DATA) && bus.HREADY;
    assign w_rdone = (r_state == ST_RD_DATA) && bus.HREADY;
    assign w_hit   = bus.HRDATA != 64'd0;
    assign w_last  = r_poll == POLL_LAST;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = start ? ST_WR_ADDR : ST_IDLE;
            ST_WR_ADDR: w_next = bus.HREADY ? ST_WR_DATA : ST_WR_ADDR;
            ST_WR_DATA: if (bus.HREADY)
                            w_next = bus.HRESP ? ST_FINISH :
                                     (r_idx == 3'd4 ? ST_RD_ADDR : ST_WR_ADDR);
            ST_RD_ADDR: w_next = bus.HREADY ? ST_RD_DATA : ST_RD_ADDR;
            ST_RD_DATA: if (bus.HREADY)
                            w_next = (bus.HRESP || w_hit || w_last) ? ST_FINISH : ST_RD_ADDR;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Reads always target the TYPE window so polling never retriggers the engine.
    assign bus.HTRANS    = (r_state == ST_WR_ADDR || r_state == ST_RD_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE    = w_wr;
    assign bus.HADDR     = w_wr ? map_addr(r_idx) : BASE_ADDR + OFF_TYPE;
    assign bus.HWDATA    = (r_state == ST_WR_DATA) ? w_item : 64'd0;
    assign bus.HSIZE     = HSIZE_64;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA;
    assign bus.HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_poll  <= '0;
            r_mode  <= 1'b0;
            r_key1  <= 64'd0;
            r_key2  <= 64'd0;
            r_key3  <= 64'd0;
            r_blk   <= 64'd0;
            r_dout  <= 64'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == ST_FINISH;
            if (r_state == ST_IDLE && start) begin
                r_mode  <= mode;
                r_key1  <= key1_in;
                r_key2  <= key2_in;
                r_key3  <= key3_in;
                r_blk   <= data_in;
                r_idx   <= 3'd0;
                r_poll  <= '0;
                r_busy  <= 1'b1;
                r_error <= 1'b0;
            end
            if (w_wdone && bus.HRESP) r_error <= 1'b1;
            if (w_wdone && !bus.HRESP && r_idx != 3'd4) r_idx <= r_idx + 3'd1;
            if (w_wdone && r_idx == 3'd4) r_poll <= '0;
            if (w_rdone) begin
                if (bus.HRESP) r_error <= 1'b1;
                else if (w_hit) r_dout <= bus.HRDATA;
                else if (w_last) r_error <= 1'b1;
                else r_poll <= r_poll + 1'b1;
            end
            if (r_state == ST_FINISH) r_busy <= 1'b0;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign data_out = r_dout;
endmodule
